// File: rtl/lc3_wb_pkg.sv
// Shared types, constants and the NZP helper for the LC3 writeback stage.
package lc3_wb_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_NPC = 2'd3
  } w_ctrl_t;

  localparam logic [2:0] PSR_N = 3'b100;
  localparam logic [2:0] PSR_Z = 3'b010;
  localparam logic [2:0] PSR_P = 3'b001;

  // Condition code of a committed value: negative wins, then zero, else positive.
  function automatic logic [2:0] nzp(input word_t value);
    if (value[DATA_W-1])
      return PSR_N;
    else if (value == '0)
      return PSR_Z;
    else
      return PSR_P;
  endfunction

endpackage

// File: rtl/lc3_regfile.sv
// 8x16 general register file: one synchronous write port, two combinational
// read ports. Reads see only registered state, so a same-cycle write is not
// bypassed to the read ports.
module lc3_regfile
  import lc3_wb_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      write_en,
  input  reg_addr_t write_addr,
  input  word_t     write_data,
  input  reg_addr_t read_addr1,
  input  reg_addr_t read_addr2,
  output word_t     read_data1,
  output word_t     read_data2
);

  word_t regs [NUM_REGS];

  // Clear every register on reset (reset beats a concurrent write), otherwise commit the write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (write_en) begin
      regs[write_addr] <= write_data;
    end
  end

  assign read_data1 = regs[read_addr1];
  assign read_data2 = regs[read_addr2];

endmodule

// File: rtl/lc3_writeback.sv
// LC3 writeback stage: selects the write-back value, commits it to the
// register file and updates the NZP status register, and serves the two
// source-register reads for the execute stage.
module lc3_writeback
  import lc3_wb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_writeback,
  input  logic [1:0]  W_Control_in,
  input  logic [15:0] npc,
  input  logic [15:0] aluout,
  input  logic [15:0] pcout,
  input  logic [15:0] memout,
  input  logic [2:0]  sr1,
  input  logic [2:0]  sr2,
  input  logic [2:0]  dr,
  output logic [15:0] VSR1,
  output logic [15:0] VSR2,
  output logic [2:0]  psr
);

  w_ctrl_t w_sel;
  word_t   dr_in;

  assign w_sel = w_ctrl_t'(W_Control_in);

  // Pick the value to be written back according to the source select.
  always_comb begin
    dr_in = aluout;
    case (w_sel)
      WB_ALU:  dr_in = aluout;
      WB_MEM:  dr_in = memout;
      WB_PC:   dr_in = pcout;
      WB_NPC:  dr_in = npc;
      default: dr_in = aluout;
    endcase
  end

  // Status flags follow the most recent commit and are cleared on reset.
  always_ff @(posedge clock) begin
    if (reset)
      psr <= 3'b000;
    else if (enable_writeback)
      psr <= nzp(dr_in);
  end

  lc3_regfile u_regfile (
    .clock      (clock),
    .reset      (reset),
    .write_en   (enable_writeback),
    .write_addr (dr),
    .write_data (dr_in),
    .read_addr1 (sr1),
    .read_addr2 (sr2),
    .read_data1 (VSR1),
    .read_data2 (VSR2)
  );

endmodule

// File: tb/tb_lc3_writeback.sv
// Scoreboard bench for lc3_writeback: stimulus pushes the expected read-back
// state for each cycle, and a negedge monitor pops and compares it.
module tb_lc3_writeback;

  logic        clock;
  logic        reset;
  logic        enable_writeback;
  logic [1:0]  W_Control_in;
  logic [15:0] npc;
  logic [15:0] aluout;
  logic [15:0] pcout;
  logic [15:0] memout;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [2:0]  dr;
  logic [15:0] VSR1;
  logic [15:0] VSR2;
  logic [2:0]  psr;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] v1;
    logic [15:0] v2;
    logic [2:0]  p;
  } exp_t;

  exp_t sb [$];
  exp_t mon_item;
  int   cycle_count = 0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] sel_v1  [4] = '{16'h0000, 16'h0005, 16'h8000, 16'h0000};
  logic [2:0]  sel_psr [4] = '{3'b000, 3'b001, 3'b100, 3'b010};

  lc3_writeback dut (
    .clock            (clock),
    .reset            (reset),
    .enable_writeback (enable_writeback),
    .W_Control_in     (W_Control_in),
    .npc              (npc),
    .aluout           (aluout),
    .pcout            (pcout),
    .memout           (memout),
    .sr1              (sr1),
    .sr2              (sr2),
    .dr               (dr),
    .VSR1             (VSR1),
    .VSR2             (VSR2),
    .psr              (psr)
  );

  // Free-running 10-time-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle index used to tag and match scoreboard entries.
  always @(posedge clock) cycle_count <= cycle_count + 1;

  task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] wctl,
                               input logic [15:0] alu, input logic [15:0] mem,
                               input logic [15:0] pc, input logic [15:0] np,
                               input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
    reset            = rst;
    enable_writeback = en;
    W_Control_in     = wctl;
    aluout           = alu;
    memout           = mem;
    pcout            = pc;
    npc              = np;
    dr               = d;
    sr1              = s1;
    sr2              = s2;
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic expectOutput(input string name, input logic [15:0] v1,
                              input logic [15:0] v2, input logic [2:0] p);
    exp_t e;
    e.cyc  = cycle_count;
    e.name = name;
    e.v1   = v1;
    e.v2   = v2;
    e.p    = p;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (VSR1 !== e.v1) begin
      errors++;
      $display("[TB] FAIL %s VSR1 (sr1=%0d): got %h expected %h", e.name, sr1, VSR1, e.v1);
    end
    checks++;
    if (VSR2 !== e.v2) begin
      errors++;
      $display("[TB] FAIL %s VSR2 (sr2=%0d): got %h expected %h", e.name, sr2, VSR2, e.v2);
    end
    checks++;
    if (psr !== e.p) begin
      errors++;
      $display("[TB] FAIL %s psr: got %b expected %b", e.name, psr, e.p);
    end
  endtask

  // Monitor: compare every expectation registered for the current cycle.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle_count) begin
      mon_item = sb.pop_front();
      if (mon_item.cyc != cycle_count) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s stale entry: cycle %0d expected cycle %0d",
                 mon_item.name, cycle_count, mon_item.cyc);
      end else begin
        checkOutput(mon_item);
      end
    end
  end

  initial begin
    // Reset for two edges while a write to R3 is requested.
    applyStimulus(1'b1, 1'b1, 2'd0, 16'h1234, 16'h0, 16'h0, 16'h0, 3'd3, 3'd0, 3'd0);
    repeat (2) stepCycle();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, i[2:0], 3'(7 - i));
      expectOutput("reset_read", 16'h0000, 16'h0000, 3'b000);
      stepCycle();
    end

    // Source select: W_Control_in 0..3 into R1..R4.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, k[1:0], 16'h0005, 16'h8000, 16'h0000, 16'h3001,
                    3'(k + 1), 3'(k), 3'(k + 1));
      expectOutput("src_sel", sel_v1[k], 16'h0000, sel_psr[k]);
      stepCycle();
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd4, 3'd1);
    expectOutput("src_sel_npc", 16'h3001, 16'h0005, 3'b001);
    stepCycle();

    // Hold: no commits with random and unknown data.
    for (int h = 0; h < 4; h++) begin
      applyStimulus(1'b0, 1'b0, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                    16'($urandom), 16'($urandom), 3'($urandom), 3'd1, 3'd2);
      expectOutput("hold", 16'h0005, 16'h8000, 3'b001);
      stepCycle();
    end
    applyStimulus(1'b0, 1'b0, 2'bxx, 16'hxxxx, 16'hxxxx, 16'hxxxx, 16'hxxxx, 3'bxxx, 3'd1, 3'd2);
    expectOutput("hold_x", 16'h0005, 16'h8000, 3'b001);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 2'd1, 16'h0, 16'hFFFF, 16'h0, 16'h0, 3'd7, 3'd7, 3'd4);
    expectOutput("mem_commit", 16'h0000, 16'h3001, 3'b001);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd7, 3'd4);
    expectOutput("mem_result", 16'hFFFF, 16'h3001, 3'b100);
    stepCycle();

    // No write-to-read bypass.
    applyStimulus(1'b0, 1'b1, 2'd0, 16'hABCD, 16'h0, 16'h0, 16'h0, 3'd5, 3'd5, 3'd5);
    expectOutput("no_bypass", 16'h0000, 16'h0000, 3'b100);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd5, 3'd5);
    expectOutput("after_write", 16'hABCD, 16'hABCD, 3'b100);
    stepCycle();

    // Back-to-back writes to R2.
    applyStimulus(1'b0, 1'b1, 2'd0, 16'h0001, 16'h0, 16'h0, 16'h0, 3'd2, 3'd2, 3'd2);
    expectOutput("b2b_first", 16'h8000, 16'h8000, 3'b100);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 2'd0, 16'h0000, 16'h0, 16'h0, 16'h0, 3'd2, 3'd2, 3'd2);
    expectOutput("b2b_second", 16'h0001, 16'h0001, 3'b001);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd2, 3'd2);
    expectOutput("b2b_last", 16'h0000, 16'h0000, 3'b010);
    stepCycle();

    // Load R0..R7 with 1111..8888 through the npc source.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 2'd3, 16'h0, 16'h0, 16'h0, 16'(16'h1111 * (i + 1)),
                    i[2:0], 3'd0, 3'd0);
      stepCycle();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, i[2:0], 3'(i + 4));
      expectOutput("load_read", 16'(16'h1111 * (i + 1)), 16'(16'h1111 * (i + 5)), 3'b100);
      stepCycle();
    end

    // Reset mid-operation with a write requested.
    applyStimulus(1'b1, 1'b1, 2'd0, 16'h1234, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd4);
    expectOutput("pre_reset", 16'h1111, 16'h5555, 3'b100);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 2'd0, 16'h7FFF, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd5);
    expectOutput("mid_reset", 16'h0000, 16'h0000, 3'b000);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd5);
    expectOutput("post_reset_commit", 16'h7FFF, 16'h0000, 3'b001);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd7, 3'd1);
    expectOutput("post_reset_clear", 16'h0000, 16'h0000, 3'b001);
    stepCycle();

    repeat (2) stepCycle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
